fp_to_dec_seq: RTL and testbench

//  Sequential, parametrised IEEE-754 single-precision to decimal converter.
//  - Aligns the significand into an INT_BITS.FRAC_BITS fixed-point word.
//  - Converts the integer part to BCD by double-dabble, one bit per cycle.
//  - Emits fraction digits by repeated x10, one digit per cycle.
//  - Valid/ready on both sides; feeds the calculator display/readout path.
//  - Flags zero, infinity, NaN and integer overflow.

---
 rtl/fp_to_dec_seq_pkg.sv | 23 ++
 rtl/fp_to_dec_seq_fix_align.sv | 50 +++++
 rtl/fp_to_dec_seq.sv | 182 ++++++++++++++++++
 tb/tb_fp_to_dec_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fp_to_dec_seq_pkg.sv
// Shared definitions for the float-to-decimal converter: IEEE-754 field
// constants, FSM state encodings, BCD nibble width and the double-dabble
// nibble correction helper.
package fp_to_dec_seq_pkg;

    localparam int          EXP_W       = 8;
    localparam int          MAN_W       = 23;
    localparam int          BIAS        = 127;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
    localparam int          BCD_W       = 4;

    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_ALIGN = 3'd1;
    localparam logic [2:0]  ST_INT   = 3'd2;
    localparam logic [2:0]  ST_FRAC  = 3'd3;
    localparam logic [2:0]  ST_DONE  = 3'd4;

    // Add 3 to any nibble that would become >= 10 after the next doubling.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/fp_to_dec_seq_fix_align.sv
// Combinational decode of an IEEE-754 single: flags and alignment of the
// significand into an INT_BITS.FRAC_BITS fixed-point word (right-shifted bits dropped).
// Ports: data_i (raw float) -> fix_o, is_zero_o, is_inf_o, is_nan_o, ovf_o.
module fp_fix_align
    import fp_to_dec_seq_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 24
) (
    input  logic [31:0]                   data_i,
    output logic [INT_BITS+FRAC_BITS-1:0] fix_o,
    output logic                          is_zero_o,
    output logic                          is_inf_o,
    output logic                          is_nan_o,
    output logic                          ovf_o
);
    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int XW = W + MAN_W + 1;   // room for the full significand before truncation

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic [MAN_W:0]   m;
    logic [XW-1:0]    mx;
    logic [XW-1:0]    fix_w;
    int               e;
    int               sh;

    assign exp_f = data_i[30:23];
    assign man_f = data_i[22:0];

    always_comb begin
        // Subnormals share the minimum normal exponent but have no hidden bit.
        e     = (exp_f == '0) ? (1 - BIAS) : (int'(exp_f) - BIAS);
        m     = {(exp_f != '0), man_f};
        sh    = e - MAN_W + FRAC_BITS;
        mx    = XW'(m);
        fix_w = '0;
        if (sh >= 0) begin
            fix_w = mx << sh;
        end else begin
            fix_w = mx >> (-sh);
        end
        fix_o     = fix_w[W-1:0];
        is_zero_o = (exp_f == '0) && (man_f == '0);
        is_inf_o  = (exp_f == EXP_SPECIAL) && (man_f == '0);
        is_nan_o  = (exp_f == EXP_SPECIAL) && (man_f != '0);
        ovf_o     = (exp_f != EXP_SPECIAL) && (e >= INT_BITS);
    end

endmodule

// File: rtl/fp_to_dec_seq.sv
// Sequential IEEE-754 single to decimal converter: align, double-dabble integer
// part one bit per cycle, x10 fraction digits one per cycle, valid/ready both sides.
// Ports: CLK/RST (async low), in_valid/in_ready/in_data, out_valid/out_ready, sign, BCD, flags.
module fp_to_dec_seq
    import fp_to_dec_seq_pkg::*;
#(
    parameter int INT_BITS    = 16,
    parameter int FRAC_BITS   = 24,
    parameter int INT_DIGITS  = 5,
    parameter int FRAC_DIGITS = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sign,
    output logic [4*INT_DIGITS-1:0]  int_bcd,
    output logic [4*FRAC_DIGITS-1:0] frac_bcd,
    output logic                     is_zero,
    output logic                     is_inf,
    output logic                     is_nan,
    output logic                     ovf
);
    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int CMAX  = (INT_BITS > FRAC_DIGITS) ? INT_BITS : FRAC_DIGITS;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int IBW   = BCD_W * INT_DIGITS;
    localparam int FBW   = BCD_W * FRAC_DIGITS;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          data_q, data_d;
    logic [INT_BITS-1:0]  ival_q, ival_d;
    logic [FRAC_BITS-1:0] fval_q, fval_d;
    logic [IBW-1:0]       ibcd_q, ibcd_d;
    logic [FBW-1:0]       fbcd_q, fbcd_d;
    logic                 sign_q, sign_d;
    logic                 zero_q, zero_d;
    logic                 inf_q, inf_d;
    logic                 nan_q, nan_d;
    logic                 ovf_q, ovf_d;

    logic [W-1:0]         fix;
    logic                 a_zero, a_inf, a_nan, a_ovf;
    logic [IBW-1:0]       adj;
    logic [FRAC_BITS+3:0] p;

    fp_fix_align #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_align (
        .data_i    (data_q),
        .fix_o     (fix),
        .is_zero_o (a_zero),
        .is_inf_o  (a_inf),
        .is_nan_o  (a_nan),
        .ovf_o     (a_ovf)
    );

    always_comb begin
        adj = '0;
        for (int i = 0; i < INT_DIGITS; i++) begin
            adj[BCD_W*i +: BCD_W] = dd_adjust(ibcd_q[BCD_W*i +: BCD_W]);
        end
        p = ({4'b0000, fval_q} << 3) + ({4'b0000, fval_q} << 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ival_d  = ival_q;
        fval_d  = fval_q;
        ibcd_d  = ibcd_q;
        fbcd_d  = fbcd_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                sign_d = data_q[31];
                zero_d = a_zero;
                inf_d  = a_inf;
                nan_d  = a_nan;
                ovf_d  = a_ovf;
                ibcd_d = '0;
                fbcd_d = '0;
                if (a_inf || a_nan || a_ovf) begin
                    // Specials bypass the integer loop but take one zero-valued
                    // fraction step, so their result lands two edges after accept.
                    ival_d  = '0;
                    fval_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_FRAC;
                end else begin
                    ival_d  = fix[W-1:FRAC_BITS];
                    fval_d  = fix[FRAC_BITS-1:0];
                    cnt_d   = CW'(INT_BITS - 1);
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                ibcd_d = {adj[IBW-2:0], ival_q[INT_BITS-1]};
                ival_d = ival_q << 1;
                if (cnt_q == '0) begin
                    cnt_d   = CW'(FRAC_DIGITS - 1);
                    state_d = ST_FRAC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FRAC: begin
                fbcd_d        = fbcd_q << BCD_W;
                fbcd_d[3:0]   = p[FRAC_BITS+3:FRAC_BITS];
                fval_d        = p[FRAC_BITS-1:0];
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ival_q  <= '0;
            fval_q  <= '0;
            ibcd_q  <= '0;
            fbcd_q  <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ival_q  <= ival_d;
            fval_q  <= fval_d;
            ibcd_q  <= ibcd_d;
            fbcd_q  <= fbcd_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sign      = sign_q;
    assign int_bcd   = ibcd_q;
    assign frac_bcd  = fbcd_q;
    assign is_zero   = zero_q;
    assign is_inf    = inf_q;
    assign is_nan    = nan_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_to_dec_seq.sv
// Directed bench for fp_to_dec_seq: hand-computed conversions, latency,
// output stall behaviour and asynchronous reset in the middle of a conversion.
module tb_fp_to_dec_seq;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [19:0] int_bcd;
    logic [23:0] frac_bcd;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    fp_to_dec_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .int_bcd   (int_bcd),
        .frac_bcd  (frac_bcd),
        .is_zero   (is_zero),
        .is_inf    (is_inf),
        .is_nan    (is_nan),
        .ovf       (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one word, return the number of edges after the accept edge until out_valid.
    task automatic convert(input logic [31:0] d, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge CLK); #1;
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (out_valid) break;
            @(posedge CLK); #1;
            lat = i;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [31:0] d, input int exp_lat,
                           input logic exp_sign, input logic [19:0] exp_int,
                           input logic [23:0] exp_frac, input logic [3:0] exp_flags);
        int lat;
        convert(d, lat);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " out_valid"}, 64'(out_valid), 64'd1);
        chk({name, " sign"}, 64'(sign), 64'(exp_sign));
        chk({name, " int_bcd"}, 64'(int_bcd), 64'(exp_int));
        chk({name, " frac_bcd"}, 64'(frac_bcd), 64'(exp_frac));
        chk({name, " flags zin o"}, 64'({is_zero, is_inf, is_nan, ovf}), 64'(exp_flags));
        handshake();
        chk({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    endtask

    localparam int LAT_N = 1 + 16 + 6;
    localparam int LAT_S = 2;

    initial begin
        logic [19:0] held_int;
        logic [23:0] held_frac;
        int          lat;

        RST       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset outputs", 64'({sign, int_bcd, frac_bcd, is_zero, is_inf, is_nan, ovf}), 64'd0);
        #10 RST = 1'b1;
        @(posedge CLK); #1;

        //      name        data          latency sign int       frac       {z,i,n,o}
        run_vec("pi",       32'h40490FDB, LAT_N, 1'b0, 20'h00003, 24'h141592, 4'b0000);
        run_vec("m123.456", 32'hC2F6E979, LAT_N, 1'b1, 20'h00123, 24'h456001, 4'b0000);
        run_vec("half",     32'h3F000000, LAT_N, 1'b0, 20'h00000, 24'h500000, 4'b0000);
        run_vec("negzero",  32'h80000000, LAT_N, 1'b1, 20'h00000, 24'h000000, 4'b1000);
        run_vec("subnorm",  32'h00000001, LAT_N, 1'b0, 20'h00000, 24'h000000, 4'b0000);
        run_vec("maxint",   32'h477FFF00, LAT_N, 1'b0, 20'h65535, 24'h000000, 4'b0000);
        run_vec("ovf",      32'h47800000, LAT_S, 1'b0, 20'h00000, 24'h000000, 4'b0001);
        run_vec("inf",      32'h7F800000, LAT_S, 1'b0, 20'h00000, 24'h000000, 4'b0100);
        run_vec("nan",      32'h7FC00000, LAT_S, 1'b0, 20'h00000, 24'h000000, 4'b0010);
        run_vec("neginf",   32'hFF800000, LAT_S, 1'b1, 20'h00000, 24'h000000, 4'b0100);

        // Stall the consumer with a competing input offered the whole time.
        convert(32'h40490FDB, lat);
        chk("stall latency", 64'(lat), 64'(LAT_N));
        held_int  = int_bcd;
        held_frac = frac_bcd;
        in_valid  = 1'b1;
        in_data   = 32'h3F000000;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("stall out_valid c%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stall in_ready c%0d", i), 64'(in_ready), 64'd0);
            chk($sformatf("stall bcd c%0d", i), 64'({int_bcd, frac_bcd}), {20'd0, 20'h00003, 24'h141592});
        end
        in_valid = 1'b0;
        handshake();
        chk("post-stall out_valid", 64'(out_valid), 64'd0);
        chk("post-stall in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge CLK);
        #1;
        chk("single handshake out_valid", 64'(out_valid), 64'd0);
        chk("single handshake in_ready", 64'(in_ready), 64'd1);
        chk("held result after handshake", 64'({held_int, held_frac}), 64'({int_bcd, frac_bcd}));
        chk("held int value", 64'(int_bcd), 64'h00003);

        // Asynchronous reset partway through the fraction loop.
        in_valid = 1'b1;
        in_data  = 32'hC2F6E979;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (1 + 16 + 3) @(posedge CLK);
        #1;
        chk("mid-frac out_valid", 64'(out_valid), 64'd0);
        chk("mid-frac int_bcd", 64'(int_bcd), 64'h00123);
        #2 RST = 1'b0;
        #1;
        chk("async reset outputs", 64'({out_valid, sign, int_bcd, frac_bcd, is_zero, is_inf, is_nan, ovf}), 64'd0);
        chk("async reset in_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("after reset in_ready", 64'(in_ready), 64'd1);
        run_vec("post-reset", 32'hC2F6E979, LAT_N, 1'b1, 20'h00123, 24'h456001, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
